// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry synchronous FIFO of {pc, instruction}; entry 0 is always the head.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o,
    output fetch_entry_t       head_o
);

    fetch_entry_t           entry_q [FIFO_DEPTH];
    fetch_entry_t           entry_d [FIFO_DEPTH];
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;

    // Next-state: shift toward the head on pop, write at the tail on push.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    entry_d[count_q[0]] = push_data_i;
                    count_d             = count_q + 2'd1;
                end
                2'b01: begin
                    entry_d[0] = entry_q[1];
                    count_d    = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry_d[0] = push_data_i;
                    end else begin
                        entry_d[0] = entry_q[1];
                        entry_d[1] = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entry_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential ROM reads, buffers responses,
// and handles redirect and halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     ROM_BYTES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] rom_address_o,
    input  logic [XLEN-1:0] rom_instruction_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            halt_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            halted_o
);

    localparam logic [XLEN-1:0] AddrMask = XLEN'(ROM_BYTES - 1);
    localparam logic [XLEN-1:0] RomEnd   = XLEN'(ROM_BYTES);

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]   count;
    fetch_entry_t       head;
    fetch_entry_t       push_data;
    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         occupancy;
    logic [XLEN-1:0]    pc_inc;
    logic [XLEN-1:0]    pc_seq;
    logic [XLEN-1:0]    redirect_pc;

    assign pop       = inst_valid_o & inst_ready_i;
    // A redirect discards the response still on its way from the ROM.
    assign push      = inflight_q & ~redirect_i;
    assign push_data = '{pc: inflight_pc_q, instr: rom_instruction_i};

    // Projected occupancy after this edge if another fetch were issued now.
    assign occupancy = 3'(count) - 3'(pop) + 3'(inflight_q) + 3'd1;
    assign issue     = (state_q == StRun) && !halt_i && !redirect_i
                       && (occupancy <= 3'(FIFO_DEPTH));

    assign pc_inc      = pc_q + 32'd4;
    assign pc_seq      = (pc_inc == RomEnd) ? '0 : pc_inc;
    assign redirect_pc = redirect_target_i & ~32'h3 & AddrMask;

    // Next pc, in-flight tracking and run/halt state.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        state_d       = state_q;

        if (redirect_i) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_seq;
        end

        case (state_q)
            StRun:    if (halt_i && !inflight_q) state_d = StHalted;
            StHalted: if (!halt_i) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .count_o     (count),
        .head_o      (head)
    );

    assign rom_address_o = pc_q;
    assign inst_valid_o  = (count != '0);
    assign inst_o        = head.instr;
    assign inst_pc_o     = head.pc;
    assign halted_o      = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected {pc, instr},
// a negedge monitor pops and compares on every accepted transfer.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    int n_vec  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .ROM_BYTES (1024)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rom_address_o     (rom_address),
        .rom_instruction_i (rom_data),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .halt_i            (halt),
        .inst_valid_o      (inst_valid),
        .inst_ready_i      (inst_ready),
        .inst_o            (inst),
        .inst_pc_o         (inst_pc),
        .halted_o          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 32'h8001_060A;
            8'd1:    return 32'h0401_1000;
            default: return 32'hC0DE_0000 | {24'h0, idx};
        endcase
    endfunction

    // 1 KiB ROM, one-cycle read latency.
    always @(posedge clk) rom_data <= rom_word(rom_address[9:2]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({pc, rom_word(pc[9:2])});
    endtask

    // Monitor: a transfer happens at the next posedge when valid & ready here.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: got pc %h, expected none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc", inst_pc, e[63:32]);
                    check("xfer_inst", inst, e[31:0]);
                end
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges; the next posedge after return is the first fetch.
    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        inst_ready = rdy;
        redirect   = 1'b0;
        halt       = 1'b0;
        #1;
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_pc", rom_address, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            wait_edges(1);
            cyc++;
        end
        inst_ready = 1'b0;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        inst_ready      = 1'b0;

        // Basic latency and first two words.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        wait_edges(1);
        check("lat_e1_valid", {31'b0, inst_valid}, 32'd0);
        check("lat_e1_pc", rom_address, 32'd4);
        wait_edges(1);
        check("lat_e2_valid", {31'b0, inst_valid}, 32'd1);
        check("lat_e2_inst", inst, 32'h8001_060A);
        check("lat_e2_pc", inst_pc, 32'd0);
        drain("basic");

        // Backpressure: FIFO fills, pc stops at 8, then back-to-back drain.
        do_reset(1'b0);
        wait_edges(5);
        check("bp_valid", {31'b0, inst_valid}, 32'd1);
        check("bp_pc_stop", rom_address, 32'd8);
        check("bp_head_pc", inst_pc, 32'd0);
        check("bp_head_inst", inst, 32'h8001_060A);
        for (int i = 0; i < 9; i++) expect_pc(32'(i * 4));
        inst_ready = 1'b1;
        drain("backpressure");

        // Redirect to unaligned 0x31 coinciding with the transfer of pc 0xC.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        for (int i = 0; i < 3; i++) expect_pc(32'h30 + 32'(i * 4));
        wait_edges(5);
        redirect        = 1'b1;
        redirect_target = 32'h0000_0031;
        wait_edges(1);
        redirect = 1'b0;
        check("redir_valid_flushed", {31'b0, inst_valid}, 32'd0);
        drain("redirect");

        // Redirect to last ROM word, pc wraps to 0.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        expect_pc(32'h3FC);
        expect_pc(32'h000);
        expect_pc(32'h004);
        wait_edges(5);
        redirect        = 1'b1;
        redirect_target = 32'h0000_03FC;
        wait_edges(1);
        redirect = 1'b0;
        drain("wrap");

        // Halt mid-stream: buffered words delivered, pc frozen, resume.
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) expect_pc(32'(i * 4));
        wait_edges(4);
        halt = 1'b1;
        wait_edges(2);
        check("halt_halted", {31'b0, halted}, 32'd1);
        wait_edges(4);
        check("halt_pc_frozen", rom_address, 32'h10);
        check("halt_empty", {31'b0, inst_valid}, 32'd0);
        check("halt_still", {31'b0, halted}, 32'd1);
        halt = 1'b0;
        wait_edges(1);
        check("halt_resumed", {31'b0, halted}, 32'd0);
        drain("halt");

        // Reset with a full FIFO; do_reset checks inst_valid drops at once.
        do_reset(1'b0);
        wait_edges(5);
        check("full_before_rst", {31'b0, inst_valid}, 32'd1);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
        drain("reset_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter ROM_BYTES, default 1024: instruction ROM size in bytes; power of two, multiple of 4.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 rom_address  out  32  byte address to the instruction ROM; equals pc continuously.
REQ-006 rom_instruction  in  32  ROM read data; valid in the cycle after the posedge that sampled rom_address.
REQ-007 redirect  in  1  branch/jump request; one-cycle pulse.
REQ-008 redirect_target  in  32  new fetch byte address, used when redirect=1.
REQ-009 halt  in  1  level; suppresses new fetches while high.
REQ-010 inst_valid  out  1  inst and inst_pc hold a fetched instruction.
REQ-011 inst_ready  in  1  consumer accepts; transfer when inst_valid and inst_ready at posedge.
REQ-012 inst  out  32  fetched instruction word.
REQ-013 inst_pc  out  32  byte address inst was fetched from.
REQ-014 halted  out  1  high in state HALTED.

Function
REQ-015 Block keeps pc, inflight flag, inflight_pc, a 2-entry FIFO of {pc, instruction}, and state in {RUN, HALTED}.
REQ-016 Issue at a posedge iff state=RUN, halt=0, redirect=0 and (count - pop + inflight + 1) <= 2, where pop = inst_valid & inst_ready.
REQ-017 On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4, wrapping to 0 when pc+4 = ROM_BYTES; otherwise inflight<=0.
REQ-018 When inflight=1 at a posedge, {inflight_pc, rom_instruction} is pushed into the FIFO.
REQ-019 Latency: issue at edge N gives inst_valid=1 after edge N+1 if the FIFO was empty; sustained throughput is one instruction per cycle while inst_ready=1.
REQ-020 inst_valid = (count != 0); inst/inst_pc show the FIFO head; outputs stay stable while inst_valid=1 and inst_ready=0.
REQ-021 Redirect has priority: pc <= {redirect_target[31:2], 2'b00} modulo ROM_BYTES; FIFO flushed; inflight<=0 so the pending ROM response is discarded; no issue that edge.
REQ-022 Redirect coinciding with a handshake: the transfer completes, then the flush applies; first redirected instruction is valid 2 edges after the redirect edge.
REQ-023 RUN->HALTED when halt=1 and inflight=0; HALTED->RUN when halt=0; buffered instructions stay deliverable in HALTED.
REQ-024 Redirect in HALTED updates pc and flushes; fetch resumes from the new pc on return to RUN.
REQ-025 Push and pop in the same edge keep count unchanged; FIFO never overflows (guaranteed by REQ-016).

Reset
REQ-026 During reset: pc=RESET_PC, inflight=0, inflight_pc=0, count=0, state=RUN, inst_valid=0, inst=0, inst_pc=0, halted=0.
REQ-027 The first issue occurs at the first posedge with reset low; reset mid-stream discards FIFO and inflight data with no output glitch to inst_valid=1.

Structure
REQ-028 Shared package fetch_pkg holds the state enum {RUN, HALTED}, FIFO depth constant 2, and the instruction/address width constant 32.
REQ-029 One sub-module, fetch_skid_buffer: 2-entry synchronous FIFO of {pc, instruction} with push, pop, flush, count, head outputs.

Verification
REQ-030 ROM word 0=32'h8001060A, word 4=32'h04011000; release reset, inst_ready=1 -> inst_valid at 2nd edge with inst=8001060A/inst_pc=0, next edge 04011000/pc=4.
REQ-031 inst_ready=0 for 5 cycles after start -> count saturates at 2, pc stops at 8, inst/inst_pc held at 0; ready=1 -> pcs 0,4,8,... back-to-back, none lost or duplicated.
REQ-032 redirect with target 32'h0000_0031 while streaming -> next delivered inst_pc=0x30, no instruction from the old path after the redirect edge.
REQ-033 ROM_BYTES=1024, redirect to 0x3FC -> delivered inst_pc sequence 0x3FC, 0x000, 0x004.
REQ-034 halt=1 mid-stream -> halted=1 within 2 edges, buffered words still delivered, pc frozen; halt=0 -> fetch resumes at frozen pc.
REQ-035 Assert reset with 2 buffered entries -> inst_valid=0 immediately; after release first inst_pc=RESET_PC.
